video_format_monitor: RTL and testbench

//  Continuous NTSC/PAL monitor on the VSYNC input. Measures every VSYNC period, requires
//  N_SAMPLES consecutive in-window, same-class measurements to lock or to switch format,
//  and drops lock on VSYNC loss. Feeds format_type/format_valid to downstream timing logic.

---
 rtl/video_format_monitor_pkg.sv | 34 +++
 rtl/video_format_monitor_sync_edge_detect.sv | 37 +++
 rtl/video_format_monitor.sv | 146 ++++++++++++++
 tb/tb_video_format_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_format_monitor_pkg.sv
// Shared constants, state encoding and helpers for the NTSC/PAL VSYNC monitor.
// Default thresholds are derived from the nominal system clock frequency.
package video_format_monitor_pkg;

    localparam logic FORMAT_NTSC = 1'b0;
    localparam logic FORMAT_PAL  = 1'b1;
    localparam logic TRUE        = 1'b1;
    localparam logic FALSE       = 1'b0;

    // 48 MHz reference: 75 Hz, 26.67 Hz, 20 Hz and 12 Hz equivalents.
    localparam int CLK_FREQ        = 48_000_000;
    localparam int DEF_MIN_CYC     = CLK_FREQ / 75;
    localparam int DEF_THRESH_CYC  = (CLK_FREQ / 80) * 3;
    localparam int DEF_MAX_CYC     = CLK_FREQ / 20;
    localparam int DEF_TIMEOUT_CYC = CLK_FREQ / 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    function automatic logic classify_period(input logic [31:0] period,
                                             input logic [31:0] thresh);
        return (period > thresh) ? FORMAT_PAL : FORMAT_NTSC;
    endfunction

    function automatic logic in_window(input logic [31:0] period,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (period >= lo) && (period <= hi);
    endfunction

endpackage

// File: rtl/video_format_monitor_sync_edge_detect.sv
// Two-flop synchroniser for the asynchronous VSYNC pin plus one history flop,
// producing a single-cycle pulse on the selected (active) edge.
module sync_edge_detect
    import video_format_monitor_pkg::*;
#(
    parameter int POL = 0
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic [1:0] sync_ff;
    logic       hist_ff;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_ff <= 2'b00;
            hist_ff <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], async_in};
            hist_ff <= sync_ff[1];
        end
    end

    // Pulse is combinational so the monitor registers the edge on the third clock.
    always_comb begin
        edge_pulse = FALSE;
        if (POL != 0) begin
            edge_pulse = sync_ff[1] & ~hist_ff;
        end else begin
            edge_pulse = ~sync_ff[1] & hist_ff;
        end
    end

endmodule

// File: rtl/video_format_monitor.sv
// Continuous NTSC/PAL classifier: measures each VSYNC period, locks or switches
// format after N_SAMPLES agreeing in-window measurements, and drops lock on VSYNC loss.
module video_format_monitor
    import video_format_monitor_pkg::*;
#(
    parameter int CNT_W       = 22,
    parameter int N_SAMPLES   = 3,
    parameter int MIN_CYC     = DEF_MIN_CYC,
    parameter int THRESH_CYC  = DEF_THRESH_CYC,
    parameter int MAX_CYC     = DEF_MAX_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int VSYNC_POL   = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             vsync_in,
    output logic             format_valid,
    output logic             format_type,
    output logic [CNT_W-1:0] period_out,
    output logic             format_changed,
    output logic             sync_lost
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [3:0]       N_C       = 4'(N_SAMPLES);

    logic active_edge;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [3:0]       agree_q,   agree_d;
    logic             cand_q,    cand_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic             type_q,    type_d;
    logic             valid_q,   valid_d;
    logic             changed_q, changed_d;
    logic             lost_q,    lost_d;

    logic             meas_class;
    logic             meas_ok;
    logic             armed;
    logic             timeout_hit;

    sync_edge_detect #(
        .POL (VSYNC_POL)
    ) u_sync (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (vsync_in),
        .edge_pulse (active_edge)
    );

    always_comb begin
        meas_class  = classify_period(32'(counter_q), 32'(THRESH_CYC));
        meas_ok     = in_window(32'(counter_q), 32'(MIN_CYC), 32'(MAX_CYC));
        armed       = (counter_q != '0);
        timeout_hit = (counter_q == TIMEOUT_C);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            agree_q   <= '0;
            cand_q    <= FORMAT_NTSC;
            period_q  <= '0;
            type_q    <= FORMAT_NTSC;
            valid_q   <= FALSE;
            changed_q <= FALSE;
            lost_q    <= FALSE;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            agree_q   <= agree_d;
            cand_q    <= cand_d;
            period_q  <= period_d;
            type_q    <= type_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            lost_q    <= lost_d;
        end
    end

    // An edge always takes priority over a coincident timeout.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        agree_d   = agree_q;
        cand_d    = cand_q;
        period_d  = period_q;
        type_d    = type_q;
        valid_d   = valid_q;
        changed_d = FALSE;
        lost_d    = lost_q;

        if (active_edge) begin
            counter_d = ONE_C;
            lost_d    = FALSE;
            if (state_q == ST_IDLE) begin
                state_d = ST_ACQUIRE;
            end

            if (armed) begin
                if (meas_ok) begin
                    period_d = counter_q;
                    if (meas_class == cand_q) begin
                        agree_d = (agree_q >= N_C) ? N_C : agree_q + 4'd1;
                    end else begin
                        cand_d  = meas_class;
                        agree_d = 4'd1;
                    end
                end else begin
                    agree_d = '0;
                end
            end

            if (armed && (agree_d == N_C)) begin
                if (state_q == ST_ACQUIRE) begin
                    type_d  = cand_d;
                    valid_d = TRUE;
                    state_d = ST_LOCKED;
                end else if ((state_q == ST_LOCKED) && (cand_d != type_q)) begin
                    type_d    = cand_d;
                    changed_d = TRUE;
                end
            end
        end else if (timeout_hit) begin
            // Counter parks at zero until the next edge re-arms it.
            counter_d = '0;
            agree_d   = '0;
            valid_d   = FALSE;
            lost_d    = TRUE;
            state_d   = ST_IDLE;
        end else if (armed) begin
            counter_d = counter_q + ONE_C;
        end
    end

    assign format_valid   = valid_q;
    assign format_type    = type_q;
    assign period_out     = period_q;
    assign format_changed = changed_q;
    assign sync_lost      = lost_q;

endmodule

// File: tb/tb_video_format_monitor.sv
// Self-checking bench for video_format_monitor: directed vector table, timeout
// and reset sequences, then randomized periods against a behavioural model.
`timescale 1ns/1ps
module tb_video_format_monitor;

    localparam int CW   = 22;
    localparam int NS   = 3;
    localparam int MINC = 800;
    localparam int THR  = 1800;
    localparam int MAXC = 2400;
    localparam int TMO  = 4000;

    logic          clk_in   = 1'b0;
    logic          rst      = 1'b1;
    logic          vsync_in = 1'b1;
    logic          format_valid;
    logic          format_type;
    logic [CW-1:0] period_out;
    logic          format_changed;
    logic          sync_lost;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural model state
    bit m_armed, m_valid, m_type, m_cand, m_chg;
    int m_pout, m_run, last_fall;

    typedef struct {
        bit do_rst;
        int gap;
        bit v;
        bit t;
        int pout;
        bit chg;
    } vec_t;

    vec_t vecs[$];

    video_format_monitor #(
        .CNT_W       (CW),
        .N_SAMPLES   (NS),
        .MIN_CYC     (MINC),
        .THRESH_CYC  (THR),
        .MAX_CYC     (MAXC),
        .TIMEOUT_CYC (TMO),
        .VSYNC_POL   (0)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .vsync_in       (vsync_in),
        .format_valid   (format_valid),
        .format_type    (format_type),
        .period_out     (period_out),
        .format_changed (format_changed),
        .sync_lost      (sync_lost)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_valid = 0; m_type = 0; m_cand = 0; m_chg = 0;
        m_pout  = 0; m_run   = 0;
    endtask

    // Spec-level update for one active edge: length of the current agreeing run decides.
    task automatic model_edge();
        int  p;
        bit  cls;
        p         = cyc - last_fall;
        last_fall = cyc;
        m_chg     = 0;
        if (!m_armed) begin
            m_armed = 1;
        end else if (p > TMO) begin
            m_valid = 0;
            m_run   = 0;
        end else if (p >= MINC && p <= MAXC) begin
            m_pout = p;
            cls    = (p > THR);
            if (cls == m_cand) begin
                m_run = (m_run >= NS) ? NS : m_run + 1;
            end else begin
                m_cand = cls;
                m_run  = 1;
            end
            if (m_run == NS) begin
                if (!m_valid) begin
                    m_valid = 1;
                    m_type  = m_cand;
                end else if (m_type != m_cand) begin
                    m_type = m_cand;
                    m_chg  = 1;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    // Falls 'gap' cycles after the previous fall (at once if gap <= 20), then waits
    // until the registered effect of the edge is visible.
    task automatic applyStimulus(input int gap);
        if (gap > 20) repeat (gap - 20) @(negedge clk_in);
        vsync_in = 1'b0;
        model_edge();
        repeat (3) @(negedge clk_in);
    endtask

    task automatic finishPulse();
        @(negedge clk_in);
        checkOutput("changed_one_cycle", format_changed, 0);
        repeat (15) @(negedge clk_in);
        vsync_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_valid"},   format_valid,   m_valid);
        checkOutput({tag, "_type"},    format_type,    m_type);
        checkOutput({tag, "_period"},  period_out,     m_pout);
        checkOutput({tag, "_changed"}, format_changed, m_chg);
        checkOutput({tag, "_lost"},    sync_lost,      0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"},   format_valid,   0);
        checkOutput({tag, "_type"},    format_type,    0);
        checkOutput({tag, "_period"},  period_out,     0);
        checkOutput({tag, "_changed"}, format_changed, 0);
        checkOutput({tag, "_lost"},    sync_lost,      0);
    endtask

    task automatic doReset();
        @(negedge clk_in);
        rst      = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk_in);
    endtask

    initial begin
        int r, p;
        model_reset();
        last_fall = 0;

        vecs.push_back('{1, 20,   0, 0, 0,    0});
        vecs.push_back('{0, 2000, 0, 0, 2000, 0});
        vecs.push_back('{0, 2000, 0, 0, 2000, 0});
        vecs.push_back('{0, 2000, 1, 1, 2000, 0});
        vecs.push_back('{0, 500,  1, 1, 2000, 0});
        vecs.push_back('{0, 2000, 1, 1, 2000, 0});
        vecs.push_back('{0, 1667, 1, 1, 1667, 0});
        vecs.push_back('{0, 2000, 1, 1, 2000, 0});
        vecs.push_back('{0, 1667, 1, 1, 1667, 0});
        vecs.push_back('{0, 1667, 1, 1, 1667, 0});
        vecs.push_back('{0, 1667, 1, 0, 1667, 1});
        vecs.push_back('{0, 800,  1, 0, 800,  0});
        vecs.push_back('{0, 799,  1, 0, 800,  0});
        vecs.push_back('{0, 2400, 1, 0, 2400, 0});
        vecs.push_back('{0, 2401, 1, 0, 2400, 0});
        vecs.push_back('{1, 20,   0, 0, 0,    0});
        vecs.push_back('{0, 1800, 0, 0, 1800, 0});
        vecs.push_back('{0, 1800, 0, 0, 1800, 0});
        vecs.push_back('{0, 1800, 1, 0, 1800, 0});
        vecs.push_back('{0, 1801, 1, 0, 1801, 0});
        vecs.push_back('{0, 1801, 1, 0, 1801, 0});
        vecs.push_back('{0, 1801, 1, 1, 1801, 1});

        repeat (3) @(negedge clk_in);
        checkReset("reset_state");

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) doReset();
            applyStimulus(vecs[i].gap);
            checkOutput($sformatf("vec%0d_valid", i),   format_valid,   vecs[i].v);
            checkOutput($sformatf("vec%0d_type", i),    format_type,    vecs[i].t);
            checkOutput($sformatf("vec%0d_period", i),  period_out,     vecs[i].pout);
            checkOutput($sformatf("vec%0d_changed", i), format_changed, vecs[i].chg);
            checkOutput($sformatf("vec%0d_lost", i),    sync_lost,      0);
            finishPulse();
        end

        $display("[TB] VSYNC loss and recovery");
        doReset();
        applyStimulus(20);
        finishPulse();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2000);
            checkModel("lock_before_loss");
            finishPulse();
        end
        repeat (4002 - 20) @(negedge clk_in);
        checkOutput("pre_timeout_valid", format_valid, 1);
        checkOutput("pre_timeout_lost",  sync_lost,    0);
        @(negedge clk_in);
        checkOutput("timeout_valid", format_valid, 0);
        checkOutput("timeout_lost",  sync_lost,    1);
        checkOutput("timeout_type",  format_type,  1);
        repeat (200) @(negedge clk_in);
        checkOutput("lost_held", sync_lost, 1);
        applyStimulus(20);
        checkModel("resume_edge");
        finishPulse();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2000);
            checkModel("relock");
            finishPulse();
        end

        $display("[TB] reset during ACQUIRE and LOCKED");
        doReset();
        applyStimulus(20);
        finishPulse();
        applyStimulus(2000);
        finishPulse();
        repeat (300) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        checkReset("rst_acquire");
        doReset();
        applyStimulus(20);
        finishPulse();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2000);
            finishPulse();
        end
        checkOutput("locked_before_rst", format_valid, 1);
        repeat (300) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        checkReset("rst_locked");

        $display("[TB] randomized periods against model");
        doReset();
        applyStimulus(20);
        checkModel("rand_first");
        finishPulse();
        for (int k = 0; k < 14; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       p = $urandom_range(300, 900);
                1:       p = $urandom_range(2300, 2500);
                2, 3, 4: p = $urandom_range(1500, 1800);
                9:       p = $urandom_range(3995, 4005);
                default: p = $urandom_range(1801, 2100);
            endcase
            applyStimulus(p);
            checkModel($sformatf("rand%0d_p%0d", k, p));
            finishPulse();
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
